// File: rtl/uart_status_tx.sv
// 8N1 UART transmitter that frames the latched LED and motor-PWM state behind HEADER.
// Define TX_CHECKSUM_EN to append an XOR checksum byte (4-byte frame instead of 3).
module uart_status_tx #(
    parameter int unsigned CLK_DIV = 5120,
    parameter logic [7:0]  HEADER  = 8'hAA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start_En_Sig,
    input  logic [1:0] led,
    input  logic [3:0] motor_pwm,
    output logic       TXD,
    output logic       Busy,
    output logic       Done_Sig,
    output logic       bps_clk
);

`ifdef TX_CHECKSUM_EN
    localparam int unsigned NBYTES = 4;
`else
    localparam int unsigned NBYTES = 3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [1:0]  led_q;
    logic [3:0]  pwm_q;
    logic [7:0]  cur_byte;
    logic        bit_end;
    logic        active;
    logic        last_byte;
    logic        tx_bit;

    assign active    = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    assign bit_end   = active && (baud_cnt == 16'(CLK_DIV - 1));
    assign last_byte = (byte_idx == 2'(NBYTES - 1));

    always_comb begin
        cur_byte = '0;
        case (byte_idx)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = {6'b0, led_q};
            2'd2:    cur_byte = {4'b0, pwm_q};
            default: begin
`ifdef TX_CHECKSUM_EN
                cur_byte = HEADER ^ {6'b0, led_q} ^ {4'b0, pwm_q};
`else
                cur_byte = '0;
`endif
            end
        endcase
    end

    always_comb begin
        state_next = state;
        tx_bit     = 1'b1;
        case (state)
            S_IDLE:  if (Start_En_Sig) state_next = S_START;
            S_START: begin
                tx_bit = 1'b0;
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                tx_bit = cur_byte[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) state_next = S_STOP;
            end
            S_STOP:  if (bit_end) state_next = last_byte ? S_DONE : S_START;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            led_q    <= '0;
            pwm_q    <= '0;
            TXD      <= 1'b1;
            Busy     <= 1'b0;
            Done_Sig <= 1'b0;
            bps_clk  <= 1'b0;
        end else begin
            state    <= state_next;
            TXD      <= tx_bit;
            Busy     <= active;
            Done_Sig <= (state == S_DONE);
            bps_clk  <= bit_end;
            if (active) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
                if (bit_end && (state == S_DATA)) bit_idx  <= bit_idx + 3'd1;
                if (bit_end && (state == S_STOP)) byte_idx <= byte_idx + 2'd1;
            end else begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                if ((state == S_IDLE) && Start_En_Sig) begin
                    led_q <= led;
                    pwm_q <= motor_pwm;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: expected bytes are queued at request time and
// compared against frames decoded from TXD, with exact cycle placement of Done_Sig.
module tb_uart_status_tx;

    localparam int unsigned CLK_DIV = 4;
`ifdef TX_CHECKSUM_EN
    localparam int NBYTES = 4;
`else
    localparam int NBYTES = 3;
`endif
    localparam int T = NBYTES * 10 * CLK_DIV;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] led;
    logic [3:0] pwm;
    logic       txd;
    logic       busy;
    logic       done;
    logic       bps;

    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    uart_status_tx #(.CLK_DIV(CLK_DIV), .HEADER(8'hAA)) dut (
        .clk(clk),
        .reset(reset),
        .Start_En_Sig(start),
        .led(led),
        .motor_pwm(pwm),
        .TXD(txd),
        .Busy(busy),
        .Done_Sig(done),
        .bps_clk(bps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [1:0] l, input logic [3:0] m);
        logic [7:0] b0, b1, b2;
        b0 = 8'hAA;
        b1 = {6'b0, l};
        b2 = {4'b0, m};
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
`ifdef TX_CHECKSUM_EN
        exp_q.push_back(b0 ^ b1 ^ b2);
`endif
    endtask

    // Call just after the acceptance edge N. Cycle c covers [N+c, N+c+1).
    task automatic recv_frame(input int reset_at, input logic hold, input int change_at);
        logic [9:0] fr[4];
        int unstable, nbps, busy_lo, done_hi, bitn, phase, stray;
        logic [7:0] e;
        unstable = 0; nbps = 0; busy_lo = 0; done_hi = 0;
        @(negedge clk);
        chk("idle_before_start", {31'b0, txd}, 32'd1);
        for (int c = 1; c <= T; c++) begin
            @(posedge clk);
            if (c == change_at) begin
                #1;
                led = 2'b10;
                pwm = 4'b0101;
            end
            @(negedge clk);
            bitn  = (c - 1) / CLK_DIV;
            phase = (c - 1) % CLK_DIV;
            if (phase == 0) fr[bitn / 10][bitn % 10] = txd;
            else if (txd !== fr[bitn / 10][bitn % 10]) unstable++;
            if (bps) nbps++;
            if (!busy) busy_lo++;
            if (done) done_hi++;
            if (c == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("reset_txd", {31'b0, txd}, 32'd1);
                chk("reset_busy", {31'b0, busy}, 32'd0);
                chk("reset_done", {31'b0, done}, 32'd0);
                reset = 1'b0;
                stray = 0;
                for (int k = 0; k < 3 * T; k++) begin
                    @(negedge clk);
                    if (done || busy || !txd) stray++;
                end
                chk("after_reset_quiet", stray, 0);
                repeat (NBYTES) void'(exp_q.pop_front());
                return;
            end
        end
        chk("bit_stability", unstable, 0);
        chk("bps_count", nbps, NBYTES * 10);
        chk("busy_during_frame", busy_lo, 0);
        chk("no_early_done", done_hi, 0);
        for (int b = 0; b < NBYTES; b++) begin
            chk("start_bit", {31'b0, fr[b][0]}, 32'd0);
            chk("stop_bit", {31'b0, fr[b][9]}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("data_byte", {24'b0, fr[b][8:1]}, {24'b0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("txd_at_done", {31'b0, txd}, 32'd1);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_width", {31'b0, done}, 32'd0);
            chk("txd_idle_after", {31'b0, txd}, 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        led   = 2'b01;
        pwm   = 4'b1010;

        // Reset held 3 cycles with a pending request.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_txd", {31'b0, txd}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
        end
        reset = 1'b0;
        push_frame(2'b01, 4'b1010);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(0, 1'b0, 0);

        // Inputs changed during B0 must not alter the frame.
        @(negedge clk);
        start = 1'b1; led = 2'b01; pwm = 4'b1010;
        push_frame(2'b01, 4'b1010);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(0, 1'b0, 5);

        // Reset during B2 data bits, then a fresh frame.
        @(negedge clk);
        start = 1'b1; led = 2'b11; pwm = 4'b0110;
        push_frame(2'b11, 4'b0110);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(95, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; led = 2'b10; pwm = 4'b0011;
        push_frame(2'b10, 4'b0011);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(0, 1'b0, 0);

        // All-ones payload.
        @(negedge clk);
        start = 1'b1; led = 2'b11; pwm = 4'b1111;
        push_frame(2'b11, 4'b1111);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(0, 1'b0, 0);

        // Start held high: back-to-back frames with 2 idle cycles between them.
        @(negedge clk);
        start = 1'b1; led = 2'b01; pwm = 4'b0101;
        push_frame(2'b01, 4'b0101);
        @(posedge clk);
        recv_frame(0, 1'b1, 0);
        push_frame(2'b01, 4'b0101);
        @(posedge clk);
        recv_frame(0, 1'b1, 0);
        push_frame(2'b01, 4'b0101);
        @(posedge clk);
        #1 start = 1'b0;
        recv_frame(0, 1'b0, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
